uart_stream_bridge: RTL and testbench

- Sits directly upstream and downstream of the UART core and owns its chip-select strobe interface (CSN/WEN/OEN, DATA_IN, DATA_OUT).
- Converts a valid/ready TX byte stream into UART write strobes, and UART received bytes into a valid/ready RX stream.
- Each RX byte carries error tags; saturating error counters are provided.
- Replaces software polling of TXRDY/RXRDY when the UART is used as a streaming port.

---
 rtl/uart_bridge_pkg.sv | 21 ++
 rtl/uart_err_counter.sv | 33 +++
 rtl/uart_stream_bridge.sv | 174 +++++++++++++++++
 tb/tb_uart_stream_bridge.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared types and limits for the UART stream bridge: strobe FSM states,
// holdoff bounds and round-robin side encoding.
package uart_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    HOLD = 2'd3
  } state_e;

  typedef enum logic {
    RR_TX = 1'b0,
    RR_RX = 1'b1
  } rr_e;

  localparam int HOLDOFF_MIN = 2;
  localparam int HOLDOFF_MAX = 15;
  localparam int HOLD_W      = 4;

endpackage

// File: rtl/uart_err_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module uart_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             aresetn,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/uart_stream_bridge.sv
// Bridges valid/ready TX/RX byte streams onto the UART core's chip-select
// strobe interface, tagging RX bytes with error flags and counting errors.
module uart_stream_bridge
  import uart_bridge_pkg::*;
#(
  parameter int HOLDOFF = 4,
  parameter int CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             aresetn,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             rx_perr,
  output logic             rx_ferr,
  input  logic             rx_ready,
  output logic             uart_csn,
  output logic             uart_wen,
  output logic             uart_oen,
  output logic [7:0]       uart_din,
  input  logic [7:0]       uart_dout,
  input  logic             uart_txrdy,
  input  logic             uart_rxrdy,
  input  logic             uart_perr,
  input  logic             uart_ferr,
  input  logic             uart_ovf,
  output logic [CNT_W-1:0] perr_cnt,
  output logic [CNT_W-1:0] ferr_cnt,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             clr_cnt
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLDOFF - 2);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  rr_e               rr_last_q, rr_last_d;
  logic              csn_q, csn_d, wen_q, wen_d, oen_q, oen_d;
  logic [7:0]        din_q, din_d;
  logic              tx_ready_q, tx_ready_d;
  logic              rx_valid_q, rx_valid_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
  logic              ovf_prev_q;
  logic              tx_req, rx_req, rd_load;

  assign tx_req  = tx_valid && uart_txrdy;
  assign rx_req  = uart_rxrdy && (!rx_valid_q || rx_ready);
  assign rd_load = (state_q == RD);

  // tx_ready is registered, so a TX grant is an offer cycle in IDLE; the
  // byte is only taken if tx_valid is still high while tx_ready is up.
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    rr_last_d  = rr_last_q;
    csn_d      = 1'b1;
    wen_d      = 1'b1;
    oen_d      = 1'b1;
    din_d      = din_q;
    tx_ready_d = 1'b0;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (tx_ready_q) begin
          if (tx_valid) begin
            din_d   = tx_data;
            csn_d   = 1'b0;
            wen_d   = 1'b0;
            state_d = WR;
          end
        end else if (hold_q == '0) begin
          if (tx_req && (!rx_req || (rr_last_q == RR_RX))) begin
            tx_ready_d = 1'b1;
            rr_last_d  = RR_TX;
          end else if (rx_req) begin
            csn_d     = 1'b0;
            oen_d     = 1'b0;
            state_d   = RD;
            rr_last_d = RR_RX;
          end
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      WR: begin
        state_d = HOLD;
        hold_d  = HOLD_LOAD;
      end
      RD: begin
        rx_data_d  = uart_dout;
        rx_perr_d  = uart_perr;
        rx_ferr_d  = uart_ferr;
        rx_valid_d = 1'b1;
        state_d    = HOLD;
        hold_d     = HOLD_LOAD;
      end
      HOLD: begin
        if (hold_q == '0) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      rr_last_q  <= RR_RX;
      csn_q      <= 1'b1;
      wen_q      <= 1'b1;
      oen_q      <= 1'b1;
      din_q      <= '0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      ovf_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rr_last_q  <= rr_last_d;
      csn_q      <= csn_d;
      wen_q      <= wen_d;
      oen_q      <= oen_d;
      din_q      <= din_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      ovf_prev_q <= uart_ovf;
    end
  end

  uart_err_counter #(.CNT_W(CNT_W)) u_perr_cnt (
    .CLK(CLK), .aresetn(aresetn), .clr_i(clr_cnt),
    .inc_i(rd_load && uart_perr), .cnt_o(perr_cnt)
  );

  uart_err_counter #(.CNT_W(CNT_W)) u_ferr_cnt (
    .CLK(CLK), .aresetn(aresetn), .clr_i(clr_cnt),
    .inc_i(rd_load && uart_ferr), .cnt_o(ferr_cnt)
  );

  uart_err_counter #(.CNT_W(CNT_W)) u_ovf_cnt (
    .CLK(CLK), .aresetn(aresetn), .clr_i(clr_cnt),
    .inc_i(uart_ovf && !ovf_prev_q), .cnt_o(ovf_cnt)
  );

  assign uart_csn = csn_q;
  assign uart_wen = wen_q;
  assign uart_oen = oen_q;
  assign uart_din = din_q;
  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign rx_perr  = rx_perr_q;
  assign rx_ferr  = rx_ferr_q;

endmodule

// File: tb/tb_uart_stream_bridge.sv
// Directed bench for uart_stream_bridge with a small UART RX FIFO model and
// TX/RX scoreboards checked on the falling clock edge.
module tb_uart_stream_bridge;

  localparam int HOLDOFF = 4;
  localparam int CNT_W   = 8;

  typedef struct packed {
    logic [7:0] d;
    logic       p;
    logic       f;
  } rxe_t;

  logic             CLK = 1'b0;
  logic             aresetn = 1'b0;
  logic             tx_valid = 1'b0;
  logic [7:0]       tx_data = 8'h00;
  logic             tx_ready;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_perr, rx_ferr;
  logic             rx_ready = 1'b0;
  logic             uart_csn, uart_wen, uart_oen;
  logic [7:0]       uart_din;
  logic [7:0]       uart_dout = 8'h00;
  logic             uart_txrdy = 1'b0;
  logic             uart_rxrdy = 1'b0;
  logic             uart_perr = 1'b0;
  logic             uart_ferr = 1'b0;
  logic             uart_ovf = 1'b0;
  logic [CNT_W-1:0] perr_cnt, ferr_cnt, ovf_cnt;
  logic             clr_cnt = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int hs_cyc = -1000;
  int last_strobe_cyc = -1000;
  int prev_txr_cyc = -1000;
  int wr_count = 0;
  int rd_count = 0;
  bit rx_pop_pending = 1'b0;

  logic [7:0] exp_tx[$];
  rxe_t       exp_rx[$];
  rxe_t       rx_fifo[$];
  byte        strobe_log[$];
  rxe_t       mon_e;
  logic [7:0] mon_b;

  uart_stream_bridge #(.HOLDOFF(HOLDOFF), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .aresetn(aresetn),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .rx_ready(rx_ready),
    .uart_csn(uart_csn), .uart_wen(uart_wen), .uart_oen(uart_oen),
    .uart_din(uart_din), .uart_dout(uart_dout),
    .uart_txrdy(uart_txrdy), .uart_rxrdy(uart_rxrdy),
    .uart_perr(uart_perr), .uart_ferr(uart_ferr), .uart_ovf(uart_ovf),
    .perr_cnt(perr_cnt), .ferr_cnt(ferr_cnt), .ovf_cnt(ovf_cnt),
    .clr_cnt(clr_cnt)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rx_push(input logic [7:0] d, input logic p, input logic f);
    rxe_t e;
    e.d = d;
    e.p = p;
    e.f = f;
    rx_fifo.push_back(e);
    exp_rx.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    while (!tx_ready && n < 100) begin
      tick();
      n++;
    end
    check("tx_ready_timeout", tx_ready, 1'b1);
    if (tx_ready) exp_tx.push_back(b);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic rx_drain(input int bound);
    int n;
    n = 0;
    while (!(rx_fifo.size() == 0 && exp_rx.size() == 0 && !rx_valid && !rx_pop_pending)
           && n < bound) begin
      tick();
      n++;
    end
    check("rx_drain_timeout", (rx_fifo.size() == 0 && exp_rx.size() == 0 && !rx_valid), 1);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_csn"}, uart_csn, 1'b1);
    check({pfx, "_wen"}, uart_wen, 1'b1);
    check({pfx, "_oen"}, uart_oen, 1'b1);
    check({pfx, "_din"}, uart_din, 8'h00);
    check({pfx, "_tx_ready"}, tx_ready, 1'b0);
    check({pfx, "_rx_valid"}, rx_valid, 1'b0);
    check({pfx, "_rx_data"}, rx_data, 8'h00);
    check({pfx, "_rx_perr"}, rx_perr, 1'b0);
    check({pfx, "_rx_ferr"}, rx_ferr, 1'b0);
    check({pfx, "_perr_cnt"}, perr_cnt, 0);
    check({pfx, "_ferr_cnt"}, ferr_cnt, 0);
    check({pfx, "_ovf_cnt"}, ovf_cnt, 0);
  endtask

  // UART RX FIFO model plus strobe/stream monitors, all on the falling edge.
  always @(negedge CLK) begin
    if (rx_pop_pending) begin
      if (rx_fifo.size() != 0) void'(rx_fifo.pop_front());
      rx_pop_pending = 1'b0;
    end
    uart_rxrdy = (rx_fifo.size() != 0);
    if (rx_fifo.size() != 0) begin
      uart_dout = rx_fifo[0].d;
      uart_perr = rx_fifo[0].p;
      uart_ferr = rx_fifo[0].f;
    end
    if (!aresetn) begin
      last_strobe_cyc = -1000;
      prev_txr_cyc    = -1000;
      hs_cyc          = -1000;
    end else begin
      check("strobe_shape",
            uart_csn ? (uart_wen && uart_oen) : (uart_wen ^ uart_oen), 1'b1);
      if (tx_ready) begin
        if (prev_txr_cyc > -1000) check("tx_ready_spacing", (cyc - prev_txr_cyc) >= HOLDOFF + 1, 1);
        prev_txr_cyc = cyc;
      end
      if (!uart_csn) begin
        if (last_strobe_cyc > -1000) check("strobe_spacing", (cyc - last_strobe_cyc) >= HOLDOFF + 1, 1);
        last_strobe_cyc = cyc;
      end
      if (!uart_csn && !uart_wen) begin
        wr_count++;
        strobe_log.push_back("W");
        check("wr_latency", cyc - hs_cyc, 1);
        check("wr_expected", exp_tx.size() != 0, 1);
        if (exp_tx.size() != 0) begin
          mon_b = exp_tx.pop_front();
          check("wr_din", uart_din, mon_b);
        end
      end
      if (!uart_csn && !uart_oen) begin
        rd_count++;
        strobe_log.push_back("R");
        check("rd_with_data", rx_fifo.size() != 0, 1);
        rx_pop_pending = 1'b1;
      end
      if (tx_ready && tx_valid) hs_cyc = cyc;
      if (rx_valid && rx_ready) begin
        check("rx_expected", exp_rx.size() != 0, 1);
        if (exp_rx.size() != 0) begin
          mon_e = exp_rx.pop_front();
          check("rx_data", rx_data, mon_e.d);
          check("rx_perr", rx_perr, mon_e.p);
          check("rx_ferr", rx_ferr, mon_e.f);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int n;
    bit took;
    string exp_s;

    repeat (3) tick();
    check_reset_outputs("reset");
    aresetn = 1'b1;
    tick();

    // Single TX and a back-to-back second byte.
    uart_txrdy = 1'b1;
    base = wr_count;
    send_byte(8'hA5);
    send_byte(8'h5A);
    repeat (10) tick();
    check("tx_two_writes", wr_count - base, 2);
    check("tx_din_held", uart_din, 8'h5A);

    // tx_valid without txrdy, then dropped: nothing written.
    base = wr_count;
    uart_txrdy = 1'b0;
    tx_data = 8'hEE;
    tx_valid = 1'b1;
    repeat (10) tick();
    tx_valid = 1'b0;
    uart_txrdy = 1'b1;
    repeat (10) tick();
    check("tx_no_write_without_txrdy", wr_count - base, 0);

    // Single RX, then a framing-tagged byte.
    rx_ready = 1'b1;
    base = rd_count;
    rx_push(8'h3C, 1'b0, 1'b0);
    rx_drain(100);
    check("rx_single_reads", rd_count - base, 1);
    rx_push(8'hC3, 1'b0, 1'b1);
    rx_drain(100);
    check("ferr_cnt_one", ferr_cnt, 1);
    check("perr_cnt_zero", perr_cnt, 0);

    // RX backpressure.
    rx_ready = 1'b0;
    base = rd_count;
    rx_push(8'h11, 1'b0, 1'b0);
    rx_push(8'h22, 1'b0, 1'b0);
    rx_push(8'h33, 1'b0, 1'b0);
    repeat (40) tick();
    check("bp_one_read", rd_count - base, 1);
    check("bp_rx_valid", rx_valid, 1'b1);
    check("bp_rx_data", rx_data, 8'h11);
    check("bp_fifo_left", rx_fifo.size(), 2);
    rx_ready = 1'b1;
    rx_drain(200);
    check("bp_all_read", rd_count - base, 3);

    // Contention from a fresh reset: TX is served first, then alternate.
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();
    strobe_log.delete();
    rx_push(8'h41, 1'b0, 1'b0);
    rx_push(8'h42, 1'b0, 1'b0);
    rx_push(8'h43, 1'b0, 1'b0);
    tx_data = 8'hC0;
    tx_valid = 1'b1;
    n = 0;
    while (strobe_log.size() < 6 && n < 300) begin
      took = tx_ready;
      if (took) exp_tx.push_back(tx_data);
      tick();
      if (took) tx_data = tx_data + 8'd1;
      n++;
    end
    tx_valid = 1'b0;
    check("cont_strobes", strobe_log.size(), 6);
    exp_s = "WRWRWR";
    for (int i = 0; i < 6 && i < strobe_log.size(); i++) check("cont_order", strobe_log[i], exp_s[i]);
    rx_drain(100);
    repeat (10) tick();
    check("cont_tx_drained", exp_tx.size(), 0);

    // Parity errors on 300 reads saturate the counter; clear returns it to 0.
    for (int i = 0; i < 300; i++) rx_push(8'(i), 1'b1, 1'b0);
    rx_drain(2500);
    check("perr_saturated", perr_cnt, 8'hFF);
    check("ferr_after_reset", ferr_cnt, 0);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("perr_cleared", perr_cnt, 0);

    // Overflow rising edges, then clear winning over a simultaneous edge.
    for (int i = 0; i < 3; i++) begin
      uart_ovf = 1'b1;
      repeat (2) tick();
      uart_ovf = 1'b0;
      repeat (2) tick();
    end
    check("ovf_three", ovf_cnt, 3);
    clr_cnt = 1'b1;
    uart_ovf = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("ovf_clr_priority", ovf_cnt, 0);
    uart_ovf = 1'b0;
    repeat (2) tick();

    // Asynchronous reset in the middle of a write strobe.
    tx_data = 8'h77;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 100) begin
      tick();
      n++;
    end
    tick();
    tx_valid = 1'b0;
    check("wr_strobe_active", {uart_csn, uart_wen}, 2'b00);
    #2;
    aresetn = 1'b0;
    #1;
    check_reset_outputs("midwr");
    tick();
    aresetn = 1'b1;
    repeat (10) tick();
    check("end_tx_queue", exp_tx.size(), 0);
    check("end_rx_queue", exp_rx.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
